// File: rtl/bomb_arm_ctrl.sv
// Arming controller for the bomb-dismantle game: latches the password, enables the
// entry checker and runs a BCD seconds countdown that ends in DEFUSED or EXPLODED.
module bomb_arm_ctrl #(
  parameter int unsigned TICK_DIV  = 1000,
  parameter int unsigned COUNT_SEC = 30
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] sw,
  input  logic       btn_set,
  input  logic       success,
  output logic [6:0] psw,
  output logic       start_input,
  output logic [3:0] sec_tens,
  output logic [3:0] sec_ones,
  output logic       defused,
  output logic       exploded,
  output logic [1:0] state
);

  localparam int unsigned PW = $clog2(TICK_DIV);
  localparam logic [PW-1:0] TickLast = PW'(TICK_DIV - 1);
  localparam logic [3:0] InitTens = 4'(COUNT_SEC / 10);
  localparam logic [3:0] InitOnes = 4'(COUNT_SEC % 10);

  typedef enum logic [1:0] {
    StIdle     = 2'b00,
    StArmed    = 2'b01,
    StDefused  = 2'b10,
    StExploded = 2'b11
  } state_e;

  state_e        state_q;
  logic          btn_prev_q;
  logic [PW-1:0] presc_q;
  logic          arm_evt;
  logic          tick;
  logic          last_sec;

  assign arm_evt  = btn_set & ~btn_prev_q;
  assign tick     = (presc_q == TickLast);
  // Treat 00 like 01 so the count can never wrap below zero.
  assign last_sec = (sec_tens == 4'd0) && (sec_ones <= 4'd1);
  assign state    = state_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StIdle;
      btn_prev_q  <= 1'b0;
      presc_q     <= '0;
      psw         <= '0;
      start_input <= 1'b0;
      sec_tens    <= InitTens;
      sec_ones    <= InitOnes;
      defused     <= 1'b0;
      exploded    <= 1'b0;
    end else begin
      btn_prev_q <= btn_set;
      case (state_q)
        StIdle: begin
          if (arm_evt && (sw != 7'd0)) begin
            psw         <= sw;
            sec_tens    <= InitTens;
            sec_ones    <= InitOnes;
            presc_q     <= '0;
            start_input <= 1'b1;
            state_q     <= StArmed;
          end
        end
        StArmed: begin
          // Success takes priority over a coincident tick; the count freezes.
          if (success) begin
            start_input <= 1'b0;
            defused     <= 1'b1;
            state_q     <= StDefused;
          end else if (tick) begin
            presc_q <= '0;
            if (last_sec) begin
              sec_tens    <= 4'd0;
              sec_ones    <= 4'd0;
              start_input <= 1'b0;
              exploded    <= 1'b1;
              state_q     <= StExploded;
            end else if (sec_ones == 4'd0) begin
              sec_ones <= 4'd9;
              sec_tens <= sec_tens - 4'd1;
            end else begin
              sec_ones <= sec_ones - 4'd1;
            end
          end else begin
            presc_q <= presc_q + PW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bomb_arm_ctrl.sv
// Directed bench for bomb_arm_ctrl with TICK_DIV=4, COUNT_SEC=12.
module tb_bomb_arm_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [6:0] sw = 7'd0;
  logic       btn_set = 1'b0;
  logic       success = 1'b0;
  logic [6:0] psw;
  logic       start_input;
  logic [3:0] sec_tens;
  logic [3:0] sec_ones;
  logic       defused;
  logic       exploded;
  logic [1:0] state;

  int checks = 0;
  int errors = 0;

  bomb_arm_ctrl #(.TICK_DIV(4), .COUNT_SEC(12)) dut (
    .clk(clk), .rst(rst), .sw(sw), .btn_set(btn_set), .success(success),
    .psw(psw), .start_input(start_input), .sec_tens(sec_tens), .sec_ones(sec_ones),
    .defused(defused), .exploded(exploded), .state(state)
  );

  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [1:0] st, input logic [6:0] pw,
                         input logic si, input logic [3:0] t, input logic [3:0] o,
                         input logic df, input logic ex);
    chk({tag, ".state"}, {6'd0, state}, {6'd0, st});
    chk({tag, ".psw"}, {1'b0, psw}, {1'b0, pw});
    chk({tag, ".start"}, {7'd0, start_input}, {7'd0, si});
    chk({tag, ".count"}, {sec_tens, sec_ones}, {t, o});
    chk({tag, ".defused"}, {7'd0, defused}, {7'd0, df});
    chk({tag, ".exploded"}, {7'd0, exploded}, {7'd0, ex});
  endtask

  task automatic arm(input logic [6:0] v);
    sw      = v;
    btn_set = 1'b1;
    step(1);
    btn_set = 1'b0;
  endtask

  task automatic do_reset;
    rst = 1'b0;
    step(2);
    rst = 1'b1;
    step(1);
  endtask

  initial begin
    // Reset state
    step(2);
    chk_all("reset", 2'b00, 7'h00, 0, 4'd1, 4'd2, 0, 0);
    rst = 1'b1;
    step(1);

    // Success ignored in IDLE
    success = 1'b1;
    step(3);
    chk_all("idle_success", 2'b00, 7'h00, 0, 4'd1, 4'd2, 0, 0);
    success = 1'b0;

    // Zero password rejected
    sw = 7'h00;
    btn_set = 1'b1;
    step(2);
    btn_set = 1'b0;
    step(1);
    chk_all("zero_psw", 2'b00, 7'h00, 0, 4'd1, 4'd2, 0, 0);

    // Arm with held button: exactly one arm, psw stable despite switch changes
    sw = 7'h55;
    btn_set = 1'b1;
    step(1);
    chk_all("arm", 2'b01, 7'h55, 1, 4'd1, 4'd2, 0, 0);
    sw = 7'h2a;
    step(9);
    chk_all("held_btn", 2'b01, 7'h55, 1, 4'd1, 4'd0, 0, 0);
    btn_set = 1'b0;
    step(3);
    chk_all("borrow", 2'b01, 7'h55, 1, 4'd0, 4'd9, 0, 0);
    step(35);
    chk_all("last_sec", 2'b01, 7'h55, 1, 4'd0, 4'd1, 0, 0);
    step(1);
    chk_all("explode", 2'b11, 7'h55, 0, 4'd0, 4'd0, 0, 1);
    success = 1'b1;
    step(5);
    chk_all("explode_hold", 2'b11, 7'h55, 0, 4'd0, 4'd0, 0, 1);
    success = 1'b0;

    // Asynchronous reset mid-ARMED
    do_reset();
    arm(7'h11);
    step(5);
    chk_all("armed2", 2'b01, 7'h11, 1, 4'd1, 4'd1, 0, 0);
    rst = 1'b0;
    #2;
    chk_all("async_rst", 2'b00, 7'h00, 0, 4'd1, 4'd2, 0, 0);
    step(1);
    rst = 1'b1;
    step(1);

    // Success 30 clocks into ARMED
    arm(7'h33);
    step(29);
    chk_all("pre_success", 2'b01, 7'h33, 1, 4'd0, 4'd5, 0, 0);
    success = 1'b1;
    step(1);
    chk_all("defuse", 2'b10, 7'h33, 0, 4'd0, 4'd5, 1, 0);
    step(10);
    chk_all("defuse_hold", 2'b10, 7'h33, 0, 4'd0, 4'd5, 1, 0);
    success = 1'b0;

    // Success coincident with the final tick
    do_reset();
    arm(7'h7f);
    step(47);
    chk_all("pre_final", 2'b01, 7'h7f, 1, 4'd0, 4'd1, 0, 0);
    success = 1'b1;
    step(1);
    chk_all("final_race", 2'b10, 7'h7f, 0, 4'd0, 4'd1, 1, 0);
    step(5);
    chk_all("final_hold", 2'b10, 7'h7f, 0, 4'd0, 4'd1, 1, 0);
    success = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
